// File: rtl/alarm_snooze.sv
// Alarm buzzer controller: ring, snooze, off and auto-timeout handling on a 1 Hz clock.
// Optional ALARM_ESCALATE_EN: buzz pulses 1 s on / 1 s off for the first 30 s of each ring.
module alarm_snooze #(
    parameter int SNOOZE_MIN = 9,
    parameter int RING_MAX   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       match,
    input  logic       alarm_on,
    input  logic       snooze_btn,
    input  logic       off_btn,
    output logic       buzz,
    output logic       snoozing,
    output logic [3:0] snooze_left,
    output logic [1:0] snooze_used
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_MAX - 1);
    localparam logic [3:0] SNZ_LEN   = 4'(SNOOZE_MIN);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    state_t     state, state_nxt;
    logic [7:0] ring_cnt, ring_cnt_nxt;
    logic [5:0] sec_cnt, sec_cnt_nxt;
    logic [3:0] left_nxt;
    logic [1:0] used_nxt;
    logic       snooze_q, off_q;
    logic       snz_p, off_p;

    assign snz_p = snooze_btn & ~snooze_q;
    assign off_p = off_btn & ~off_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ring_cnt    <= '0;
            sec_cnt     <= '0;
            snooze_left <= '0;
            snooze_used <= '0;
            snooze_q    <= 1'b0;
            off_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            ring_cnt    <= ring_cnt_nxt;
            sec_cnt     <= sec_cnt_nxt;
            snooze_left <= left_nxt;
            snooze_used <= used_nxt;
            snooze_q    <= snooze_btn;
            off_q       <= off_btn;
        end
    end

    // NOTE: every signal gets a hold default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
        sec_cnt_nxt  = sec_cnt;
        left_nxt     = snooze_left;
        used_nxt     = snooze_used;

        if (!alarm_on) begin
            state_nxt    = IDLE;
            ring_cnt_nxt = '0;
            sec_cnt_nxt  = '0;
            left_nxt     = '0;
            used_nxt     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt    = RING;
                        ring_cnt_nxt = '0;
                        used_nxt     = '0;
                    end
                end
                RING: begin
                    if (off_p) begin
                        state_nxt = DONE;
                    end else if (snz_p || ring_cnt == RING_LAST) begin
                        if (snooze_used == SNZ_MAX) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt   = SNOOZE;
                            left_nxt    = SNZ_LEN;
                            sec_cnt_nxt = '0;
                            used_nxt    = snooze_used + 2'd1;
                        end
                    end else begin
                        ring_cnt_nxt = ring_cnt + 8'd1;
                    end
                end
                SNOOZE: begin
                    if (off_p) begin
                        state_nxt   = DONE;
                        left_nxt    = '0;
                        sec_cnt_nxt = '0;
                    end else if (sec_cnt == 6'd59) begin
                        sec_cnt_nxt = '0;
                        if (snooze_left == 4'd1) begin
                            state_nxt    = RING;
                            ring_cnt_nxt = '0;
                            left_nxt     = '0;
                        end else begin
                            left_nxt = snooze_left - 4'd1;
                        end
                    end else begin
                        sec_cnt_nxt = sec_cnt + 6'd1;
                    end
                end
                DONE: begin
                    // Hold until the match minute passes so the alarm cannot re-trigger.
                    if (!match) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef ALARM_ESCALATE_EN
    assign buzz = (state == RING) && ((ring_cnt >= 8'd30) || !ring_cnt[0]);
`else
    assign buzz = (state == RING);
`endif
    assign snoozing = (state == SNOOZE);

endmodule
